// File: rtl/fighter_motion_pkg.sv
// Shared game constants and the vertical state type used by the fighter motion logic.
package fighter_motion_pkg;

   localparam int MAP_X          = 320;
   localparam int MAP_Y          = 240;
   localparam int PLAYER_X       = 64;
   localparam int PLAYER_Y       = 128;
   localparam int SQUAT_PLAYER_Y = 64;
   localparam int STEP_X         = 8;
   localparam int V              = 16;
   localparam int G              = 2;
   localparam int MAX_J          = 2 * V / G;
   localparam int KB_STEP        = 4;
   localparam int KB_CYC         = 8;

   // Arena limits for the right-side fighter; the left instance overrides X_MIN/X_INIT.
   localparam int ENEMY_X_MIN = PLAYER_X + 16;
   localparam int ARENA_X_MAX = MAP_X - PLAYER_X;

   typedef enum logic {V_GROUND, V_AIR} vstate_t;

endpackage

// File: rtl/fighter_motion_jump_profile.sv
// Combinational ballistic height h(t) = V0*t - G*t*t/2, usable for any projectile.
module jump_profile #(
   parameter int V0  = 16,
   parameter int G   = 2,
   parameter int T_W = 5,
   parameter int H_W = 20
) (
   input  logic        [T_W-1:0] i_t,
   output logic signed [H_W-1:0] o_h
);

   localparam logic signed [H_W-1:0] C_V0    = H_W'(V0);
   localparam logic signed [H_W-1:0] C_HALFG = H_W'(G / 2);

   logic signed [H_W-1:0] w_t;

   assign w_t = $signed({{(H_W-T_W){1'b0}}, i_t});
   // G is even, so G*t*t/2 is exact as (G/2)*t*t.
   assign o_h = (C_V0 * w_t) - (C_HALFG * w_t * w_t);

endmodule

// File: rtl/fighter_motion.sv
// Per-fighter motion controller: walking, knockback/hit-stun, jumping and squatting on frame ticks.
module fighter_motion
   import fighter_motion_pkg::*;
#(
   parameter int SIDE    = 1,
   parameter int X_W     = 11,
   parameter int Y_W     = 10,
   parameter int X_MIN   = fighter_motion_pkg::ENEMY_X_MIN,
   parameter int X_MAX   = fighter_motion_pkg::ARENA_X_MAX,
   parameter int X_INIT  = fighter_motion_pkg::ARENA_X_MAX,
   parameter int Y_GND   = fighter_motion_pkg::PLAYER_Y - fighter_motion_pkg::MAP_Y,
   parameter int Y_SQ    = fighter_motion_pkg::SQUAT_PLAYER_Y - fighter_motion_pkg::MAP_Y,
   parameter int STEP_X  = fighter_motion_pkg::STEP_X,
   parameter int V0      = fighter_motion_pkg::V,
   parameter int G       = fighter_motion_pkg::G,
   parameter int KB_STEP = fighter_motion_pkg::KB_STEP,
   parameter int KB_CYC  = fighter_motion_pkg::KB_CYC
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tick,
   input  logic                  right,
   input  logic                  left,
   input  logic                  jump,
   input  logic                  squat,
   input  logic                  defend,
   input  logic                  hit,
   output logic signed [X_W-1:0] x,
   output logic signed [Y_W-1:0] y,
   output logic                  isD,
   output logic                  isQ,
   output logic                  isJ,
   output logic                  isK
);

   localparam int T_MAX = 2 * V0 / G;
   localparam int T_W   = $clog2(T_MAX + 1);
   localparam int KB_W  = $clog2(KB_CYC + 1);
   localparam int H_W   = 2 * Y_W;
   localparam int XS_W  = X_W + 1;

   localparam logic signed [XS_W-1:0] C_XMIN  = XS_W'(X_MIN);
   localparam logic signed [XS_W-1:0] C_XMAX  = XS_W'(X_MAX);
   localparam logic signed [XS_W-1:0] C_WALK  = XS_W'(STEP_X);
   localparam logic signed [XS_W-1:0] C_KB    = (SIDE != 0) ? XS_W'(KB_STEP) : XS_W'(-KB_STEP);
   localparam logic signed [Y_W-1:0]  C_YGND  = Y_W'(Y_GND);
   localparam logic signed [Y_W-1:0]  C_YSQ   = Y_W'(Y_SQ);
   localparam logic        [KB_W-1:0] C_KBCYC = KB_W'(KB_CYC);

   vstate_t                  r_state;
   logic        [T_W-1:0]    r_t;
   logic        [KB_W-1:0]   r_kb;
   logic signed [X_W-1:0]    r_x;
   logic signed [Y_W-1:0]    r_y;
   logic signed [Y_W-1:0]    r_ybase;

   vstate_t                  w_state_nxt;
   logic        [T_W-1:0]    w_t_nxt;
   logic        [T_W-1:0]    w_t_inc;
   logic        [KB_W-1:0]   w_kb_nxt;
   logic signed [X_W-1:0]    w_x_nxt;
   logic signed [Y_W-1:0]    w_y_nxt;
   logic signed [Y_W-1:0]    w_ybase_nxt;
   logic signed [H_W-1:0]    w_h;
   logic signed [XS_W-1:0]   w_step;
   logic signed [XS_W-1:0]   w_xsum;
   logic signed [X_W-1:0]    w_xclamp;
   logic                     w_stun;
   logic                     w_guard;
   logic                     w_hit_acc;
   logic                     w_jump_acc;

   assign w_stun     = (r_kb != '0);
   assign w_guard    = defend && (r_state == V_GROUND) && !w_stun;
   assign w_hit_acc  = hit && !w_guard;
   assign w_jump_acc = jump && !w_stun && !squat && !w_hit_acc;
   assign w_t_inc    = r_t + T_W'(1);

   jump_profile #(
      .V0  (V0),
      .G   (G),
      .T_W (T_W),
      .H_W (H_W)
   ) u_jump_profile (
      .i_t (w_t_inc),
      .o_h (w_h)
   );

   // Knockback overrides walking; the sum carries one spare bit so the clamp sees overflow.
   always_comb begin
      w_step = '0;
      if (w_stun) begin
         w_step = C_KB;
      end else if (right) begin
         w_step = C_WALK;
      end else if (left) begin
         w_step = -C_WALK;
      end
      w_xsum = $signed({r_x[X_W-1], r_x}) + w_step;
      if (w_xsum < C_XMIN) begin
         w_xclamp = C_XMIN[X_W-1:0];
      end else if (w_xsum > C_XMAX) begin
         w_xclamp = C_XMAX[X_W-1:0];
      end else begin
         w_xclamp = w_xsum[X_W-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= V_GROUND;
         r_t     <= '0;
         r_kb    <= '0;
         r_x     <= X_W'(X_INIT);
         r_y     <= C_YGND;
         r_ybase <= C_YGND;
      end else begin
         r_state <= w_state_nxt;
         r_t     <= w_t_nxt;
         r_kb    <= w_kb_nxt;
         r_x     <= w_x_nxt;
         r_y     <= w_y_nxt;
         r_ybase <= w_ybase_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_t_nxt     = r_t;
      w_kb_nxt    = r_kb;
      w_x_nxt     = r_x;
      w_y_nxt     = r_y;
      w_ybase_nxt = r_ybase;
      if (tick) begin
         w_x_nxt = w_xclamp;
         if (w_hit_acc) begin
            w_kb_nxt = C_KBCYC;
         end else if (w_stun) begin
            w_kb_nxt = r_kb - KB_W'(1);
         end
         case (r_state)
            V_GROUND: begin
               if (w_jump_acc) begin
                  w_state_nxt = V_AIR;
                  w_ybase_nxt = r_y;
                  w_t_nxt     = '0;
               end else begin
                  w_y_nxt = squat ? C_YSQ : C_YGND;
               end
            end
            V_AIR: begin
               w_t_nxt = w_t_inc;
               // Landing once the arc height returns to zero or below.
               if (w_h[H_W-1] || (w_h == '0)) begin
                  w_y_nxt     = r_ybase;
                  w_state_nxt = V_GROUND;
               end else begin
                  w_y_nxt = r_ybase + w_h[Y_W-1:0];
               end
            end
            default: w_state_nxt = V_GROUND;
         endcase
      end
   end

   always_comb begin
      x   = r_x;
      y   = r_y;
      isD = w_guard;
      isQ = squat && (r_state == V_GROUND);
      isJ = (r_state == V_AIR);
      isK = w_stun;
   end

endmodule

// File: tb/tb_fighter_motion.sv
// Self-checking bench for fighter_motion with default (right-side) parameters.
module tb_fighter_motion;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               tick = 1'b0, right = 1'b0, left = 1'b0, jump = 1'b0;
   logic               squat = 1'b0, defend = 1'b0, hit = 1'b0;
   logic signed [10:0] x;
   logic signed [9:0]  y;
   logic               isD, isQ, isJ, isK;

   localparam logic [3:0] FD = 4'b1000, FQ = 4'b0100, FJ = 4'b0010, FK = 4'b0001, F0 = 4'b0000;

   typedef struct {
      logic       tk, r, l, j, s, d, h;
      int         ex, ey;
      logic [3:0] ef;
   } vec_t;

   vec_t exp_q[$];
   vec_t tbl[$];
   int   errors = 0;
   int   checks = 0;

   fighter_motion dut (
      .clk(clk), .rst(rst), .tick(tick), .right(right), .left(left), .jump(jump),
      .squat(squat), .defend(defend), .hit(hit), .x(x), .y(y),
      .isD(isD), .isQ(isQ), .isJ(isJ), .isK(isK)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(input logic tk, input logic r, input logic l, input logic j,
                               input logic s, input logic d, input logic h,
                               input int ex, input int ey, input logic [3:0] ef);
      vec_t v;
      v.tk = tk; v.r = r; v.l = l; v.j = j; v.s = s; v.d = d; v.h = h;
      v.ex = ex; v.ey = ey; v.ef = ef;
      return v;
   endfunction

   function automatic int arc_h(input int t);
      return 16 * t - t * t;
   endfunction

   task automatic chk(input string nm, input int act, input int want);
      checks++;
      if (act != want) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d", nm, act, want);
      end
   endtask

   task automatic chk_out(input string nm, input int ex, input int ey, input logic [3:0] ef);
      chk({nm, ".x"}, int'(x), ex);
      chk({nm, ".y"}, int'(y), ey);
      chk({nm, ".flags"}, int'({isD, isQ, isJ, isK}), int'(ef));
   endtask

   task automatic run(input vec_t v, input string nm);
      vec_t e;
      tick = v.tk; right = v.r; left = v.l; jump = v.j;
      squat = v.s; defend = v.d; hit = v.h;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: scoreboard empty, got x=%0d, want an entry", nm, int'(x));
      end else begin
         e = exp_q.pop_front();
         chk_out(nm, e.ex, e.ey, e.ef);
      end
   endtask

   initial begin
      int xe;
      // Ground sequence starting from x=256, y=-112, kb=0.
      tbl.push_back(mk(1,0,0,0,1,0,0, 256, -176, FQ));
      tbl.push_back(mk(1,0,0,1,1,0,0, 256, -176, FQ));
      tbl.push_back(mk(1,0,0,0,0,0,0, 256, -112, F0));
      tbl.push_back(mk(1,0,1,0,0,0,0, 248, -112, F0));
      tbl.push_back(mk(1,1,1,0,0,0,0, 256, -112, F0));
      tbl.push_back(mk(1,0,0,0,0,1,1, 256, -112, FD));
      tbl.push_back(mk(1,0,0,0,0,0,0, 256, -112, F0));
      tbl.push_back(mk(0,0,0,0,0,0,1, 256, -112, F0));
      tbl.push_back(mk(1,0,0,0,0,0,0, 256, -112, F0));

      repeat (3) @(posedge clk);
      #1;
      chk_out("reset", 256, -112, F0);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) run(mk(0,1,1,1,0,0,0, 256, -112, F0), "no_tick");

      for (int k = 1; k <= 30; k++) begin
         xe = 256 - 8 * k;
         if (xe < 80) xe = 80;
         run(mk(1,0,1,0,0,0,0, xe, -112, F0), "clamp_left");
      end
      for (int k = 1; k <= 30; k++) begin
         xe = 80 + 8 * k;
         if (xe > 256) xe = 256;
         run(mk(1,1,0,0,0,0,0, xe, -112, F0), "clamp_right");
      end

      run(mk(1,0,0,1,0,0,0, 256, -112, FJ), "jump_launch");
      for (int t = 1; t <= 16; t++) begin
         run(mk(1,0,0,(t == 2),(t == 3),0,0, 256,
                (arc_h(t) > 0) ? -112 + arc_h(t) : -112,
                (arc_h(t) > 0) ? FJ : F0), "jump_arc");
         if (t == 1)  chk("arc_t1",  int'(y), -97);
         if (t == 8)  chk("arc_t8",  int'(y), -48);
         if (t == 15) chk("arc_t15", int'(y), -97);
      end
      run(mk(1,0,0,0,0,0,0, 256, -112, F0), "after_land");

      foreach (tbl[i]) run(tbl[i], "table");

      for (int k = 1; k <= 7; k++) run(mk(1,0,1,0,0,0,0, 256 - 8 * k, -112, F0), "walk_to_200");
      run(mk(1,0,0,0,0,0,1, 200, -112, FK), "kb_hit");
      for (int k = 1; k <= 8; k++)
         run(mk(1,(k % 2 == 0),(k % 2 == 1),0,0,0,0, 200 + 4 * k, -112, (k < 8) ? FK : F0), "kb_stun");

      for (int k = 1; k <= 10; k++) run(mk(1,0,1,0,0,0,0, 232 - 8 * k, -112, F0), "walk_to_152");
      run(mk(1,0,0,0,0,0,1, 152, -112, FK), "reload_hit1");
      for (int k = 1; k <= 4; k++) run(mk(1,1,0,0,0,0,0, 152 + 4 * k, -112, FK), "reload_pre");
      run(mk(1,0,0,0,0,0,1, 172, -112, FK), "reload_hit2");
      for (int k = 1; k <= 8; k++)
         run(mk(1,0,1,0,0,0,0, 172 + 4 * k, -112, (k < 8) ? FK : F0), "reload_post");

      // Airborne hit with guard held: guard is ground-only, arc keeps its schedule.
      run(mk(1,0,0,1,0,1,0, 204, -112, FJ), "air_launch");
      for (int t = 1; t <= 16; t++) begin
         xe = (t <= 2) ? 204 : ((t <= 10) ? 204 + 4 * (t - 2) : 236);
         run(mk(1,0,0,0,0,1,(t == 2), xe,
                (arc_h(t) > 0) ? -112 + arc_h(t) : -112,
                (arc_h(t) > 0) ? (FJ | ((t >= 2 && t <= 9) ? FK : F0)) : FD), "air_hit");
      end

      run(mk(1,0,0,1,0,0,1, 236, -112, FK), "hit_beats_jump");
      for (int k = 1; k <= 8; k++) begin
         xe = 236 + 4 * k;
         if (xe > 256) xe = 256;
         run(mk(1,0,0,0,0,0,0, xe, -112, (k < 8) ? FK : F0), "kb_clamp");
      end

      for (int k = 1; k <= 3; k++) run(mk(1,0,1,0,0,0,0, 256 - 8 * k, -112, F0), "walk_to_232");
      run(mk(1,0,0,1,0,0,0, 232, -112, FJ), "rst_launch");
      run(mk(1,0,0,0,0,0,1, 232, -97, FJ | FK), "rst_t1");
      run(mk(1,0,0,0,0,0,0, 236, -84, FJ | FK), "rst_t2");
      run(mk(1,0,0,0,0,0,0, 240, -73, FJ | FK), "rst_t3");
      #2;
      rst = 1'b1;
      #1;
      chk_out("async_rst", 256, -112, F0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      run(mk(1,0,0,0,0,0,0, 256, -112, F0), "post_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
